game_flow_ctrl: RTL



---
 rtl/game_pkg.sv | 22 ++
 rtl/tick_gen.sv | 36 +++
 rtl/game_flow_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the road-fighter play sequencer.
// Contents:
//   state_t      - game state encoding (ST_IDLE..ST_OVER). The values are
//                  visible on state_dbg.
//   SEC_CYCLES   - default cycles per score tick (1 s at 50 MHz)
//   DROP_CYCLES  - default cycles between obstacle drops
//   CRASH_CYCLES - default cycles spent in the crash state
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_CRASH   = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  localparam int SEC_CYCLES   = 50_000_000;
  localparam int DROP_CYCLES  = 13_000_000;
  localparam int CRASH_CYCLES = 100_000_000;

endpackage

// File: rtl/tick_gen.sv
// Enabled, clearable modulo-N counter.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset (counter to 0)
//   en    - count enable
//   clr   - synchronous clear (counter to 0). Takes priority over en.
//   tick  - combinational. High during the enabled cycle in which the count
//           is N-1, which is the cycle that wraps the count back to 0.
module tick_gen #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int         W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/game_flow_ctrl.sv
// Play sequencer for the road-fighter game. It owns the game state and
// generates the enables for the road/car datapath.
// Ports:
//   clk         - system clock
//   reset       - synchronous, active-high reset
//   start       - start/restart request (level or pulse)
//   colision    - collision flag from the road datapath (level)
//   run_en      - the datapath may scroll and steer (state PLAY)
//   drop        - one-cycle obstacle drop pulse
//   respawn     - one-cycle pulse that clears obstacles and recentres the car
//   crash_flash - red-flash enable. Toggles while the game is in CRASH.
//   score       - current score. Saturates at all-ones.
//   lives       - remaining lives
//   game_over   - high in state OVER
//   state_dbg   - encoded state
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int SEC_CYCLES   = game_pkg::SEC_CYCLES,
  parameter int DROP_CYCLES  = game_pkg::DROP_CYCLES,
  parameter int CRASH_CYCLES = game_pkg::CRASH_CYCLES,
  parameter int FLASH_LOG2   = 17,
  parameter int LIVES        = 3,
  parameter int SCORE_W      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               colision,
  output logic               run_en,
  output logic               drop,
  output logic               respawn,
  output logic               crash_flash,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               game_over,
  output logic [2:0]         state_dbg
);

  localparam int                CW         = (CRASH_CYCLES > 1) ? $clog2(CRASH_CYCLES) : 1;
  localparam logic [CW-1:0]     CRASH_LAST = CW'(CRASH_CYCLES - 1);
  localparam logic [2:0]        LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t        state, state_nx;
  logic [CW-1:0] crash_cnt, crash_nx;
  logic          sec_tick, drop_tick;
  logic          playing, fresh_game, crash_done;

  assign playing    = (state == ST_PLAY);
  // Starting from IDLE or OVER reloads the game. While PLAY is active, start
  // has no effect, so holding the button does not reset the run.
  assign fresh_game = ((state == ST_IDLE) || (state == ST_OVER)) && start;
  assign crash_done = (state == ST_CRASH) && (crash_cnt == CRASH_LAST);

  // The play counters run only in PLAY. In CRASH and RESPAWN they hold their
  // value, so the score and drop phase continue where they stopped.
  tick_gen #(.N(SEC_CYCLES)) u_sec (
    .clk   (clk),
    .reset (reset),
    .en    (playing),
    .clr   (fresh_game),
    .tick  (sec_tick)
  );

  tick_gen #(.N(DROP_CYCLES)) u_drop (
    .clk   (clk),
    .reset (reset),
    .en    (playing),
    .clr   (fresh_game),
    .tick  (drop_tick)
  );

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    crash_nx = crash_cnt;
    unique case (state)
      ST_IDLE:    if (start) state_nx = ST_PLAY;
      ST_PLAY: begin
        if (colision) begin
          state_nx = ST_CRASH;
          crash_nx = '0;
        end
      end
      ST_CRASH: begin
        if (crash_done) begin
          state_nx = (lives == 3'd0) ? ST_OVER : ST_RESPAWN;
          crash_nx = '0;
        end else begin
          crash_nx = crash_cnt + 1'b1;
        end
      end
      // colision is ignored for this single cycle.
      ST_RESPAWN: state_nx = ST_PLAY;
      ST_OVER:    if (start) state_nx = ST_PLAY;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      crash_cnt <= '0;
    end else begin
      state     <= state_nx;
      crash_cnt <= crash_nx;
    end
  end

  // The score and lives registers are updated in the same cycle that a
  // collision is taken, so a score tick in that cycle is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      score <= '0;
      lives <= LIVES_INIT;
    end else if (fresh_game) begin
      score <= '0;
      lives <= LIVES_INIT;
    end else if (playing) begin
      if (sec_tick && (score != SCORE_MAX)) score <= score + 1'b1;
      if (colision && (lives != 3'd0))      lives <= lives - 1'b1;
    end
  end

  // The outputs are decoded from the next state. This keeps them registered
  // and also aligned with the state that they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_en      <= 1'b0;
      drop        <= 1'b0;
      respawn     <= 1'b0;
      crash_flash <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      run_en      <= (state_nx == ST_PLAY);
      drop        <= drop_tick && (state_nx == ST_PLAY);
      respawn     <= (state_nx == ST_RESPAWN);
      crash_flash <= (state_nx == ST_CRASH) && crash_nx[FLASH_LOG2];
      game_over   <= (state_nx == ST_OVER);
    end
  end

  assign state_dbg = state;

endmodule
